// File: rtl/neuron_pkg.sv
// neuron_pkg
// Shared definitions for the neuron parameter loader slice.
//   - default geometry of the output neuron (N_IN, W_W, X_W)
//   - FRAME_BYTES: bytes per load frame at the default geometry
//   - state_t: loader FSM states with fixed encodings IDLE=0 .. FIRE=4
//   - x_hi_mask(): bits of the high activation byte that carry data
package neuron_pkg;

  localparam int N_IN_DEF    = 8;
  localparam int W_W_DEF     = 8;
  localparam int X_W_DEF     = 10;
  localparam int FRAME_BYTES = N_IN_DEF * 3;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_W    = 3'd1,
    LOAD_X_LO = 3'd2,
    LOAD_X_HI = 3'd3,
    FIRE      = 3'd4
  } state_t;

  // Activations are 9..16 bits wide, so the high byte carries X_W-8 data
  // bits; everything above them must be zero in a well-formed frame.
  function automatic logic [7:0] x_hi_mask(input int x_w);
    return 8'hFF >> (16 - x_w);
  endfunction

endpackage

// File: rtl/neuron_param_loader_if.sv
// neuron_param_loader_if
// Byte-serial load port plus the parallel neuron-side buses.
//   start  begin a new frame (loader honours it only when idle)
//   data   input byte, valid qualifies it, ready = loader accepting
//   w      N_IN packed weights,     w[i] at [i*W_W +: W_W]
//   x      N_IN packed activations, x[i] at [i*X_W +: X_W]
//   en     one-cycle fire pulse towards the neuron
//   busy   frame in progress
//   err    sticky malformed-frame flag
// master: pin-side logic driving bytes; slave: the loader.
interface neuron_param_loader_if
  import neuron_pkg::*;
#(
  parameter int N_IN = N_IN_DEF,
  parameter int W_W  = W_W_DEF,
  parameter int X_W  = X_W_DEF
);

  logic                  start;
  logic [7:0]            data;
  logic                  valid;
  logic                  ready;
  logic [N_IN*W_W-1:0]   w;
  logic [N_IN*X_W-1:0]   x;
  logic                  en;
  logic                  busy;
  logic                  err;

  modport master (
    output start, data, valid,
    input  ready, w, x, en, busy, err
  );

  modport slave (
    input  start, data, valid,
    output ready, w, x, en, busy, err
  );

endinterface

// File: rtl/neuron_param_loader.sv
// neuron_param_loader
// Collects N_IN weights (one byte each) followed by N_IN activations
// (low byte, then high byte) from a valid/ready byte stream, holds them
// on parallel buses and pulses en for one cycle once the frame is done.
// Ports:
//   clk_i  clock
//   rst_i  asynchronous active-low reset, clears every register
//   bus    neuron_param_loader_if slave modport (see interface header)
module neuron_param_loader
  import neuron_pkg::*;
#(
  parameter int N_IN = N_IN_DEF,
  parameter int W_W  = W_W_DEF,
  parameter int X_W  = X_W_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  neuron_param_loader_if.slave   bus
);

  localparam int               CNT_W    = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_IN - 1);
  localparam logic [7:0]       HI_MASK  = x_hi_mask(X_W);

  state_t              state_q;
  state_t              state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [W_W-1:0]      w_q [N_IN];
  logic [X_W-1:0]      x_q [N_IN];
  logic                err_q;
  logic                load_state;
  logic                accept;
  logic                cnt_last;
  logic [N_IN*W_W-1:0] w_flat;
  logic [N_IN*X_W-1:0] x_flat;

  // ready depends only on the state register, so accept never loops back
  // into the next-state logic combinationally.
  assign load_state = (state_q == LOAD_W) || (state_q == LOAD_X_LO) ||
                      (state_q == LOAD_X_HI);
  assign accept     = bus.valid && load_state;
  assign cnt_last   = (cnt_q == CNT_LAST);

  assign bus.ready  = load_state;
  assign bus.en     = (state_q == FIRE);
  assign bus.busy   = (state_q != IDLE);
  assign bus.err    = err_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (bus.start)          state_d = LOAD_W;
      LOAD_W:    if (accept && cnt_last) state_d = LOAD_X_LO;
      LOAD_X_LO: if (accept)             state_d = LOAD_X_HI;
      LOAD_X_HI: if (accept)             state_d = cnt_last ? FIRE : LOAD_X_LO;
      FIRE:                              state_d = IDLE;
      default:                           state_d = IDLE;
    endcase
  end

  // The counter walks the weights once and then the activations once; it
  // is rewound when the weight phase ends and advances only after each
  // activation high byte. A bad high byte flags err but the frame runs on.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < N_IN; i++) begin
        w_q[i] <= '0;
        x_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            cnt_q <= '0;
            err_q <= 1'b0;
          end
        end
        LOAD_W: begin
          if (accept) begin
            w_q[cnt_q] <= bus.data[W_W-1:0];
            cnt_q      <= cnt_last ? '0 : cnt_q + CNT_W'(1);
          end
        end
        LOAD_X_LO: begin
          if (accept) begin
            x_q[cnt_q][7:0] <= bus.data;
          end
        end
        LOAD_X_HI: begin
          if (accept) begin
            x_q[cnt_q][X_W-1:8] <= bus.data[X_W-9:0];
            if ((bus.data & ~HI_MASK) != 8'd0) begin
              err_q <= 1'b1;
            end
            if (!cnt_last) begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_flat = '0;
    x_flat = '0;
    for (int i = 0; i < N_IN; i++) begin
      w_flat[i*W_W +: W_W] = w_q[i];
      x_flat[i*X_W +: X_W] = x_q[i];
    end
  end

  assign bus.w = w_flat;
  assign bus.x = x_flat;

endmodule
